// File: rtl/v810_ifetch.sv
// v810_ifetch: instruction prefetch queue feeding v810_exec.
// Issues sequential halfword reads, tracks them through a fixed-latency
// pipe, and buffers {halfword, pc} pairs in a small FIFO. The consumer
// takes the head over a valid/ready handshake. A flush drops everything
// queued or in flight and restarts fetch at a new PC.
module v810_ifetch #(
  parameter int          DEPTH    = 4,
  parameter int          MEM_LAT  = 1,
  parameter logic [31:0] RESET_PC = 32'hFFFF_FFF0
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        CE,
  input  logic        FLUSH,
  input  logic [31:0] FLUSH_PC,
  output logic [31:0] MEM_A,
  output logic        MEM_RD,
  input  logic [15:0] MEM_D,
  output logic [15:0] Q_DATA,
  output logic [31:0] Q_PC,
  output logic        Q_VALID,
  input  logic        Q_READY
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  // Occupancy (count + inflight) needs headroom for up to 3 extra entries.
  localparam int OW = CW + 2;
  localparam logic [OW-1:0] DEPTH_O = OW'(DEPTH);

  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [MEM_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [31:0]        pipe_pc_q   [MEM_LAT];
  logic [31:0]        pipe_pc_d   [MEM_LAT];
  logic [15:0]        fifo_data_q [DEPTH];
  logic [15:0]        fifo_data_d [DEPTH];
  logic [31:0]        fifo_pc_q   [DEPTH];
  logic [31:0]        fifo_pc_d   [DEPTH];
  logic [CW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      rd_ptr_q, rd_ptr_d;

  logic [CW-1:0]      count_s;
  logic [OW-1:0]      inflight_s;
  logic [OW-1:0]      occ_s;
  logic               mem_rd_s;
  logic               cap_s;
  logic               pop_s;
  logic [31:0]        flush_pc_s;

  // Occupancy, issue permission and the capture/pop strobes.
  always_comb begin
    count_s    = wr_ptr_q - rd_ptr_q;
    inflight_s = {OW{1'b0}};
    for (int i = 0; i < MEM_LAT; i++) begin
      inflight_s = inflight_s + {{(OW-1){1'b0}}, pipe_vld_q[i]};
    end
    occ_s      = OW'(count_s) + inflight_s;
    // Reads already in flight reserve a slot, so a capture can never overflow.
    mem_rd_s   = CE & ~RES & ~FLUSH & (occ_s < DEPTH_O);
    cap_s      = pipe_vld_q[MEM_LAT-1];
    pop_s      = (count_s != {CW{1'b0}}) & Q_READY;
    flush_pc_s = FLUSH_PC & 32'hFFFF_FFFE;
  end

  // Next-state: fetch PC, latency pipe and FIFO; flush overrides all else.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    pipe_vld_d  = pipe_vld_q;
    pipe_pc_d   = pipe_pc_q;
    fifo_data_d = fifo_data_q;
    fifo_pc_d   = fifo_pc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (CE && FLUSH) begin
      fetch_pc_d = flush_pc_s;
      pipe_vld_d = {MEM_LAT{1'b0}};
      wr_ptr_d   = {CW{1'b0}};
      rd_ptr_d   = {CW{1'b0}};
    end else if (CE) begin
      if (mem_rd_s) begin
        fetch_pc_d = fetch_pc_q + 32'd2;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      pipe_vld_d[0] = mem_rd_s;
      pipe_pc_d[0]  = fetch_pc_q;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_vld_d[i] = pipe_vld_q[i-1];
        pipe_pc_d[i]  = pipe_pc_q[i-1];
      end
      if (cap_s) begin
        fifo_data_d[wr_ptr_q[AW-1:0]] = MEM_D;
        fifo_pc_d[wr_ptr_q[AW-1:0]]   = pipe_pc_q[MEM_LAT-1];
        wr_ptr_d                      = wr_ptr_q + CW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + CW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end else begin
      fetch_pc_d = fetch_pc_q;
    end
  end

  // State registers with asynchronous reset to the boot fetch address.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      fetch_pc_q <= RESET_PC;
      pipe_vld_q <= {MEM_LAT{1'b0}};
      for (int i = 0; i < MEM_LAT; i++) begin
        pipe_pc_q[i] <= 32'h0000_0000;
      end
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data_q[i] <= 16'h0000;
        fifo_pc_q[i]   <= RESET_PC;
      end
      wr_ptr_q <= {CW{1'b0}};
      rd_ptr_q <= {CW{1'b0}};
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_pc_q   <= pipe_pc_d;
      fifo_data_q <= fifo_data_d;
      fifo_pc_q   <= fifo_pc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Outputs: memory request and the combinational view of the queue head.
  always_comb begin
    MEM_A   = fetch_pc_q;
    MEM_RD  = mem_rd_s;
    Q_VALID = (count_s != {CW{1'b0}});
    Q_DATA  = fifo_data_q[rd_ptr_q[AW-1:0]];
    Q_PC    = fifo_pc_q[rd_ptr_q[AW-1:0]];
  end

endmodule

// File: tb/tb_v810_ifetch.sv
// Bench for v810_ifetch: two instances (MEM_LAT=1 and MEM_LAT=3, DEPTH=4)
// share one directed stimulus stream. Each has its own memory model, an
// issue-address checker and a pop scoreboard filled by the stimulus.
module tb_v810_ifetch;

  logic        CLK = 1'b0;
  logic        RES, CE, FLUSH, Q_READY;
  logic [31:0] FLUSH_PC;

  logic [31:0] mem_a1, q_pc1, mem_a3, q_pc3;
  logic        mem_rd1, q_valid1, mem_rd3, q_valid3;
  logic [15:0] mem_d1, q_data1, mem_d3, q_data3;

  always #5 CLK = ~CLK;

  v810_ifetch #(.DEPTH(4), .MEM_LAT(1), .RESET_PC(32'hFFFF_FFF0)) d1 (
    .CLK(CLK), .RES(RES), .CE(CE), .FLUSH(FLUSH), .FLUSH_PC(FLUSH_PC),
    .MEM_A(mem_a1), .MEM_RD(mem_rd1), .MEM_D(mem_d1),
    .Q_DATA(q_data1), .Q_PC(q_pc1), .Q_VALID(q_valid1), .Q_READY(Q_READY));

  v810_ifetch #(.DEPTH(4), .MEM_LAT(3), .RESET_PC(32'hFFFF_FFF0)) d3 (
    .CLK(CLK), .RES(RES), .CE(CE), .FLUSH(FLUSH), .FLUSH_PC(FLUSH_PC),
    .MEM_A(mem_a3), .MEM_RD(mem_rd3), .MEM_D(mem_d3),
    .Q_DATA(q_data3), .Q_PC(q_pc3), .Q_VALID(q_valid3), .Q_READY(Q_READY));

  int n_checks = 0;
  int n_errors = 0;

  // mem[i] = 16'h1000 + i, i counted in halfwords from the reset PC.
  function automatic logic [15:0] mem_word(input logic [31:0] a);
    logic [31:0] off;
    off = (a - 32'hFFFF_FFF0) >> 1;
    return 16'h1000 + off[15:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory models: sample requests on the falling edge, shift on CE edges.
  logic        s_ce, s_rd1, s_rd3;
  logic [31:0] s_a1, s_a3;
  logic        m1_vld;
  logic [31:0] m1_a;
  logic [2:0]  m3_vld;
  logic [31:0] m3_a [3];

  initial begin
    m1_vld = 1'b0; m3_vld = 3'b000; s_ce = 1'b0; s_rd1 = 1'b0; s_rd3 = 1'b0;
  end

  always @(negedge CLK) begin
    s_ce <= CE; s_rd1 <= mem_rd1; s_a1 <= mem_a1; s_rd3 <= mem_rd3; s_a3 <= mem_a3;
  end

  always @(posedge CLK) begin
    if (s_ce) begin
      m1_vld  <= s_rd1;  m1_a    <= s_a1;
      m3_vld  <= {m3_vld[1:0], s_rd3};
      m3_a[0] <= s_a3;   m3_a[1] <= m3_a[0];  m3_a[2] <= m3_a[1];
    end
  end

  assign mem_d1 = m1_vld    ? mem_word(m1_a)    : 16'hDEAD;
  assign mem_d3 = m3_vld[2] ? mem_word(m3_a[2]) : 16'hDEAD;

  // Scoreboard: expected {pc, data} stream per instance, refilled on restart.
  logic [47:0] sbq1[$];
  logic [47:0] sbq3[$];
  logic [47:0] sb_e1, sb_e3;
  logic [31:0] iss_exp1, iss_exp3;
  int          iss_cnt1, iss_cnt3, pops1, pops3;

  task automatic restart(input logic [31:0] pc);
    logic [31:0] p;
    sbq1.delete();
    sbq3.delete();
    for (int i = 0; i < 40; i++) begin
      p = pc + 32'(2 * i);
      sbq1.push_back({p, mem_word(p)});
      sbq3.push_back({p, mem_word(p)});
    end
    iss_exp1 = pc; iss_exp3 = pc; iss_cnt1 = 0; iss_cnt3 = 0;
  endtask

  // Monitor: check issue addresses and every accepted pop on the falling edge.
  always @(negedge CLK) begin
    if (CE && !RES && !FLUSH) begin
      if (mem_rd1) begin
        chk("issue_addr_lat1", mem_a1, iss_exp1);
        iss_exp1 += 32'd2; iss_cnt1++;
      end
      if (mem_rd3) begin
        chk("issue_addr_lat3", mem_a3, iss_exp3);
        iss_exp3 += 32'd2; iss_cnt3++;
      end
      if (q_valid1 && Q_READY) begin
        pops1++;
        if (sbq1.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL pop_lat1: unexpected entry pc %h, scoreboard empty", q_pc1);
        end else begin
          sb_e1 = sbq1.pop_front();
          chk("pop_pc_lat1", q_pc1, sb_e1[47:16]);
          chk("pop_data_lat1", {16'h0000, q_data1}, {16'h0000, sb_e1[15:0]});
        end
      end
      if (q_valid3 && Q_READY) begin
        pops3++;
        if (sbq3.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL pop_lat3: unexpected entry pc %h, scoreboard empty", q_pc3);
        end else begin
          sb_e3 = sbq3.pop_front();
          chk("pop_pc_lat3", q_pc3, sb_e3[47:16]);
          chk("pop_data_lat3", {16'h0000, q_data3}, {16'h0000, sb_e3[15:0]});
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic do_flush(input logic [31:0] pc_in, input logic rdy);
    FLUSH = 1'b1; FLUSH_PC = pc_in; Q_READY = rdy;
    restart(pc_in & 32'hFFFF_FFFE);
    tick();
    FLUSH = 1'b0;
  endtask

  int base_pops;

  initial begin
    pops1 = 0; pops3 = 0;
    RES = 1'b1; CE = 1'b1; FLUSH = 1'b0; FLUSH_PC = 32'h0; Q_READY = 1'b0;
    restart(32'hFFFF_FFF0);
    #12;
    // Reset state
    chk("rst_mem_a",   mem_a1,   32'hFFFF_FFF0);
    chk("rst_mem_rd",  mem_rd1,  32'd0);
    chk("rst_q_valid", q_valid1, 32'd0);
    chk("rst_q_data",  q_data1,  32'd0);
    chk("rst_q_pc",    q_pc1,    32'hFFFF_FFF0);
    chk("rst_q_valid3", q_valid3, 32'd0);
    chk("rst_mem_a3",  mem_a3,   32'hFFFF_FFF0);

    // Startup streaming, wrap at the top of the address space
    tick();
    RES = 1'b0; Q_READY = 1'b1;
    #1;
    chk("start_mem_rd", mem_rd1, 32'd1);
    tick();                                   // E1
    chk("start_e1_valid1", q_valid1, 32'd0);
    tick();                                   // E2
    chk("start_e2_valid1", q_valid1, 32'd1);
    chk("start_e2_pc1",    q_pc1,    32'hFFFF_FFF0);
    chk("start_e2_data1",  q_data1,  32'h1000);
    tick();                                   // E3
    chk("start_e3_valid3", q_valid3, 32'd0);
    tick();                                   // E4
    chk("start_e4_valid3", q_valid3, 32'd1);
    chk("start_e4_pc3",    q_pc3,    32'hFFFF_FFF0);
    chk("start_e4_pc1",    q_pc1,    32'hFFFF_FFF4);
    for (int k = 5; k <= 14; k++) begin
      tick();
      chk("stream_nogap1", q_valid1, 32'd1);
      if (k == 10) chk("wrap_pc1", q_pc1, 32'h0000_0000);
    end

    // Backpressure: exactly DEPTH issues, then drain in order
    do_flush(32'h0000_0100, 1'b0);
    chk("bp_flush_a1", mem_a1, 32'h0000_0100);
    chk("bp_flush_v1", q_valid1, 32'd0);
    repeat (10) tick();
    chk("bp_issues1", iss_cnt1, 32'd4);
    chk("bp_issues3", iss_cnt3, 32'd4);
    chk("bp_rd_idle1", mem_rd1, 32'd0);
    chk("bp_rd_idle3", mem_rd3, 32'd0);
    chk("bp_head1", q_pc1, 32'h0000_0100);
    base_pops = pops1;
    Q_READY = 1'b1;
    repeat (12) tick();
    chk("bp_resume1", 32'(iss_cnt1 > 4), 32'd1);
    chk("bp_resume3", 32'(iss_cnt3 > 4), 32'd1);
    chk("bp_drain1", 32'(pops1 - base_pops >= 8), 32'd1);

    // Flush with reads in flight; also flush + pop + capture on one edge (lat1)
    do_flush(32'h0000_0201, 1'b1);
    chk("fl_mem_a1", mem_a1, 32'h0000_0200);
    chk("fl_mem_a3", mem_a3, 32'h0000_0200);
    chk("fl_empty1", q_valid1, 32'd0);
    chk("fl_empty3", q_valid3, 32'd0);
    tick();                                   // E1
    chk("fl_e1_v1", q_valid1, 32'd0);
    chk("fl_e1_v3", q_valid3, 32'd0);
    tick();                                   // E2
    chk("fl_e2_v1", q_valid1, 32'd1);
    chk("fl_e2_pc1", q_pc1, 32'h0000_0200);
    tick();                                   // E3
    chk("fl_e3_v3", q_valid3, 32'd0);
    tick();                                   // E4
    chk("fl_e4_v3", q_valid3, 32'd1);
    chk("fl_e4_pc3", q_pc3, 32'h0000_0200);
    repeat (6) tick();

    // Same-edge pop and capture at count 2 (lat1); ready ignored when empty (lat3)
    do_flush(32'h0000_0300, 1'b0);
    repeat (3) tick();                        // E1..E3
    chk("pc2_head1", q_pc1, 32'h0000_0300);
    chk("pc2_valid3", q_valid3, 32'd0);
    Q_READY = 1'b1;
    tick();                                   // E4: pop + capture on lat1
    Q_READY = 1'b0;
    chk("pc2_after_pop1", q_pc1, 32'h0000_0302);
    chk("pc2_ignored3", q_pc3, 32'h0000_0300);
    chk("pc2_valid3b", q_valid3, 32'd1);
    repeat (6) tick();
    chk("pc2_issues1", iss_cnt1, 32'd5);
    chk("pc2_issues3", iss_cnt3, 32'd4);
    Q_READY = 1'b1;
    repeat (10) tick();

    // CE gating during streaming
    do_flush(32'h0000_0400, 1'b1);
    repeat (4) tick();                        // E1..E4
    chk("ce_head1", q_pc1, 32'h0000_0404);
    chk("ce_head3", q_pc3, 32'h0000_0400);
    CE = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("ce0_rd1", mem_rd1, 32'd0);
      chk("ce0_rd3", mem_rd3, 32'd0);
      chk("ce0_pc1", q_pc1, 32'h0000_0404);
      chk("ce0_data1", q_data1, 32'(mem_word(32'h0000_0404)));
      chk("ce0_v1", q_valid1, 32'd1);
      chk("ce0_pc3", q_pc3, 32'h0000_0400);
      tick();
    end
    CE = 1'b1;
    tick();
    chk("ce1_pc1", q_pc1, 32'h0000_0406);
    chk("ce1_pc3", q_pc3, 32'h0000_0402);
    repeat (6) tick();

    // Async reset between edges with three entries queued (lat1)
    do_flush(32'h0000_0500, 1'b0);
    repeat (4) tick();                        // E1..E4
    chk("ar_before_v1", q_valid1, 32'd1);
    chk("ar_before_pc1", q_pc1, 32'h0000_0500);
    RES = 1'b1;
    restart(32'hFFFF_FFF0);
    #1;
    chk("ar_v1", q_valid1, 32'd0);
    chk("ar_a1", mem_a1, 32'hFFFF_FFF0);
    chk("ar_rd1", mem_rd1, 32'd0);
    chk("ar_v3", q_valid3, 32'd0);
    chk("ar_a3", mem_a3, 32'hFFFF_FFF0);
    tick();
    RES = 1'b0; Q_READY = 1'b1;
    tick(); tick();                           // E1, E2
    chk("ar_restart_v1", q_valid1, 32'd1);
    chk("ar_restart_pc1", q_pc1, 32'hFFFF_FFF0);
    repeat (6) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/v810_ifetch.md
Name: v810_ifetch

Overview:
- Instruction prefetch queue sitting directly upstream of v810_exec.
- Issues sequential 16-bit halfword reads to instruction memory, absorbs the fixed memory read latency, and buffers halfwords with their PCs in a small FIFO.
- Presents the queue head to the execute stage over a valid/ready handshake.
- A flush (taken branch, jump, exception) discards queued and in-flight data and restarts fetch at a new PC.

Parameters:
- DEPTH, 4: FIFO entries (halfwords); power of two, 2..16.
- MEM_LAT, 1: CE-cycles from read issue to data sampled on MEM_D; 1..3.
- RESET_PC, 32'hFFFF_FFF0: fetch address after reset.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RES  in  1  reset, asynchronous, active-high.
- CE  in  1  clock enable; state advances only on edges with CE=1.
- FLUSH  in  1  restart fetch at FLUSH_PC.
- FLUSH_PC  in  32  new fetch address; bit 0 ignored (forced 0).
- MEM_A  out  32  halfword read address (current fetch PC).
- MEM_RD  out  1  read issued this cycle.
- MEM_D  in  16  read data, valid MEM_LAT CE-cycles after issue.
- Q_DATA  out  16  head halfword.
- Q_PC  out  32  address of head halfword.
- Q_VALID  out  1  head entry valid.
- Q_READY  in  1  consumer takes the head this cycle.

Behaviour:
- Reset (async, RES=1):
  - Fetch PC = RESET_PC; FIFO empty; in-flight pipe cleared.
  - MEM_A = RESET_PC, MEM_RD = 0, Q_VALID = 0, Q_DATA = 0, Q_PC = RESET_PC.
  - Reset mid-operation drops all queued and in-flight data immediately.
- Issue:
  - MEM_RD = CE & ~RES & ~FLUSH & (count + inflight < DEPTH).
  - MEM_A is the registered fetch PC.
  - On an edge with MEM_RD=1: fetch PC += 2, modulo 2^32 (0xFFFF_FFFE wraps to 0x0000_0000).
- Latency pipe: MEM_LAT-stage shift register of {valid, pc}, advancing on CE edges. inflight = number of valid stages.
- Capture:
  - When the last stage is valid on a CE edge, {MEM_D, pc} is written to the FIFO tail.
  - Space is guaranteed by the issue rule, so overflow is impossible. An overflow is a verification error.
- Pop:
  - Q_VALID = (count != 0).
  - Q_DATA and Q_PC come combinationally from the head registers.
  - On a CE edge with Q_VALID & Q_READY, the head advances.
  - Q_READY with Q_VALID=0 is ignored.
- Same-edge capture and pop: both take effect; count unchanged. A capture into an empty FIFO is not bypassed; it is visible the following cycle.
- Flush (CE edge with FLUSH=1):
  - FIFO emptied; all pipe valid bits cleared, so stale returns are discarded.
  - Fetch PC = {FLUSH_PC[31:1], 1'b0}.
  - No issue on the flush edge.
  - Flush wins over a same-edge pop and capture.
  - Issue resumes on the next CE edge.
- CE=0: all state holds; MEM_RD=0; Q_* outputs are stable.
- First-data latency from reset release or flush (no stalls): 1 issue edge + MEM_LAT edges, so Q_VALID rises after edge MEM_LAT+1.
- Steady state with Q_READY=1: one halfword per CE cycle.
- Width rules: count and pointers are clog2(DEPTH)+1 bits; PC arithmetic is unsigned 32-bit.

Test Plan:
- Reset/startup:
  - Stimulus: MEM_LAT=1, mem[i] = 16'h1000+i, RES released, Q_READY=1.
  - Required: MEM_A sequence FFFF_FFF0, FFFF_FFF2, ….
  - Required: Q_VALID high after edge 2; Q_PC/Q_DATA stream FFFF_FFF0/mem, one per cycle.
  - Required: wrap FFFF_FFFE → 0000_0000 with no gap.
- Backpressure:
  - Stimulus: Q_READY=0, DEPTH=4.
  - Required: exactly 4 MEM_RD pulses, then MEM_RD=0; count=4.
  - Stimulus: release Q_READY.
  - Required: 4 entries drain in order and issue resumes.
  - Required: no entry lost or duplicated.
- Flush with reads in flight:
  - Stimulus: MEM_LAT=3, steady fetch, FLUSH=1 with FLUSH_PC=0000_0201.
  - Required: next MEM_A=0000_0200; no pre-flush data ever appears on Q.
  - Required: first post-flush Q_PC=0000_0200, valid after edge 4.
- Simultaneous events:
  - Stimulus 1: FLUSH, Q_READY, and a returning read on one edge.
  - Required: FIFO empty next cycle and the returned data is dropped.
  - Stimulus 2: pop and capture on the same edge at count=2.
  - Required: count stays 2.
- CE gating:
  - Stimulus: toggle CE 1-0-0-1 during streaming.
  - Required: Q_* stable and MEM_RD=0 while CE=0; output sequence identical to the CE=1 run.
- Async reset mid-burst:
  - Stimulus: assert RES between edges while count=3.
  - Required: Q_VALID=0 and MEM_A=RESET_PC immediately, before the next edge.
